// File: rtl/queue_access_arbiter.sv
// Arbiter sharing one 5-entry signed event queue between two producers and a consumer.
// Optional stall statistics counter enabled by defining QUEUE_ARB_STATS_EN.
module queue_access_arbiter #(
  parameter int DEPTH = 5,
  parameter int DW    = 64,
  parameter int CW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           prod_valid,
  input  logic [2*DW-1:0]      prod_data,
  output logic [1:0]           prod_ready,
  input  logic                 cons_req,
  output logic                 cons_valid,
  output logic signed [DW-1:0] cons_data,
  input  logic                 flush,
  output logic                 busy,
  output logic [CW-1:0]        count,
  output logic                 err,
  output logic                 q_push,
  output logic                 q_pop,
  output logic signed [DW-1:0] q_data,
  input  logic                 q_push_valid,
  input  logic                 q_pop_valid,
  input  logic signed [DW-1:0] q_out,
  output logic [15:0]          stall_cnt
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t state, state_next;
  logic   rr_ptr, grant_idx;
  logic   pend_push, pend_pop, pend_run_pop;
  logic   active, not_full, not_empty;

  assign active    = en && !rst;
  assign not_full  = count < CW'(DEPTH);
  assign not_empty = count != '0;
  assign busy      = (state == DRAIN);

  // Grant, pop and drain decisions; flush wins over everything in RUN for that cycle.
  always_comb begin
    state_next = state;
    grant_idx  = 1'b0;
    prod_ready = 2'b00;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    q_data     = '0;
    if (active) begin
      case (state)
        RUN: begin
          if (flush) begin
            state_next = DRAIN;
          end else begin
            if (not_full && (prod_valid != 2'b00)) begin
              if (prod_valid == 2'b11) grant_idx = ~rr_ptr;
              else                     grant_idx = prod_valid[1];
              prod_ready = grant_idx ? 2'b10 : 2'b01;
              q_push     = 1'b1;
              q_data     = prod_data[grant_idx*DW +: DW];
            end
            q_pop = cons_req && not_empty;
          end
        end
        DRAIN: begin
          q_pop = not_empty;
          if (!not_empty && !pend_pop) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Occupancy mirror, response tracking and consumer return path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      count        <= '0;
      rr_ptr       <= 1'b0;
      pend_push    <= 1'b0;
      pend_pop     <= 1'b0;
      pend_run_pop <= 1'b0;
      cons_valid   <= 1'b0;
      cons_data    <= '0;
      err          <= 1'b0;
    end else if (en) begin
      state        <= state_next;
      pend_push    <= q_push;
      pend_pop     <= q_pop;
      pend_run_pop <= q_pop && (state == RUN);
      if (q_push) rr_ptr <= grant_idx;
      case ({q_push, q_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if ((pend_push && !q_push_valid) || (pend_pop && !q_pop_valid)) err <= 1'b1;
      cons_valid <= pend_pop && q_pop_valid && pend_run_pop;
      if (pend_pop && q_pop_valid && pend_run_pop) cons_data <= q_out;
    end else begin
      cons_valid <= 1'b0;
    end
  end

`ifdef QUEUE_ARB_STATS_EN
  logic stall;
  assign stall = en && (prod_valid != 2'b00) && ((state == DRAIN) || !not_full);

  // Saturating count of producer cycles lost to a full queue or a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/queue_access_arbiter.md
Name: queue_access_arbiter

Overview:
- Controller that shares the single 5-entry signed 64-bit event queue between two producer streams and one consumer.
- Round-robin arbitration of push requests; suppresses pushes when full and pops when empty.
- Issues the queue's push/pop/data strobes and mirrors queue occupancy.
- Returns popped data to the consumer with a valid flag; provides a flush (drain) sequence and a sticky protocol-error flag.
- Sits between the stream producers / evaluation consumer and the queue's topEntity.

Parameters:
- DEPTH, 5, queue capacity; must match the attached queue.
- DW, 64, data width, signed.
- CW, 3, occupancy counter width, equal to clog2(DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  clock enable; when low, all state is held and no strobes are issued.
- prod_valid  in  2  producer i has data.
- prod_data  in  2*DW  producer i data in bits [i*DW +: DW].
- prod_ready  out  2  combinational grant; a transfer occurs when prod_valid[i] and prod_ready[i] are both high.
- cons_req  in  1  consumer pop request, level; sampled each cycle.
- cons_valid  out  1  registered one-cycle pulse: popped data is available.
- cons_data  out  DW  registered popped value; holds until the next cons_valid.
- flush  in  1  pulse; starts a drain.
- busy  out  1  high while draining.
- count  out  CW  registered mirrored occupancy.
- err  out  1  sticky protocol-error flag; cleared only by rst.
- q_push  out  1  queue push strobe, combinational.
- q_pop  out  1  queue pop strobe, combinational.
- q_data  out  DW  queue data, combinational; 0 when q_push is low.
- q_push_valid  in  1  queue response, one cycle after q_push.
- q_pop_valid  in  1  queue response, one cycle after q_pop.
- q_out  in  DW  queue pop data, valid with q_pop_valid.

Behaviour:
- Reset (async, rst=1): state=RUN, count=0, rr_ptr=0, pend_push=0, pend_pop=0, cons_valid=0, cons_data=0, busy=0, err=0.
  - All strobes and prod_ready are 0 while rst is high.
- en=0: prod_ready=0, q_push=0, q_pop=0; registers hold; cons_valid forced to 0 next edge.
- FSM RUN:
  - Push arbitration: if count<DEPTH, grant one valid producer per cycle.
    - If both are valid, grant the producer not equal to rr_ptr. rr_ptr is the index of the last producer granted.
    - On grant, rr_ptr takes the granted index.
  - Full: no push while count==DEPTH, even if a pop is issued the same cycle (no pop-credit bypass).
  - Pop: q_pop = cons_req && count>0. A pop on empty is not forwarded and produces no cons_valid.
  - Simultaneous push and pop with count==0: push issued, pop suppressed.
  - Count update: count_next = count + push − pop; never wraps.
  - Transition: flush=1 → DRAIN. flush takes priority and suppresses that cycle's grants and consumer pop.
- FSM DRAIN:
  - prod_ready=0, busy=1.
  - q_pop=1 each cycle while count>0; popped data is discarded (no cons_valid).
  - Transition: when count==0 and no pop is pending → RUN. busy falls the same edge.
  - flush during DRAIN is ignored.
- Response tracking: pend_push / pend_pop register the issued strobes.
  - Next cycle, if pend_push && !q_push_valid, or pend_pop && !q_pop_valid, err is set.
- Consumer return: on pend_pop && q_pop_valid in RUN-origin pops, cons_data<=q_out and cons_valid<=1 for one cycle.
  - Consumer latency: cons_req → cons_valid is 2 edges (strobe edge + response edge).
- Reset mid-operation: pending responses are dropped, no err is raised, count=0.
  - The queue is assumed reset by the same rst.

Optional Feature:
- Macro: QUEUE_ARB_STATS_EN.
- When defined, adds output stall_cnt [15:0]: a saturating count of cycles where any prod_valid is high but no grant is given because the queue is full or draining. Reset to 0; holds at 16'hFFFF.
- When undefined, stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Single push: prod_valid=01, data0=1 → prod_ready=01, q_push=1, q_data=1; next edge count=1, no err.
- Round-robin: both valid for 4 cycles (data0=10, data1=20) → grant order 1,0,1,0 after reset; q_data sequence 20,10,20,10; count=4.
- Full and stall: hold prod_valid=11 past count=5 → prod_ready=00, q_push=0, count stays 5; stall_cnt increments by 1 per cycle when QUEUE_ARB_STATS_EN is defined.
- Pop path: queue holding 3,2,1 (1 oldest), cons_req=1 for one cycle → q_pop=1; two edges later cons_valid=1, cons_data=1; count 3→2.
- Empty corner: count=0, prod_valid=01 (data 7) with cons_req=1 → q_push=1, q_pop=0, no cons_valid; next cycle cons_req → cons_data=7.
- Flush: count=4, flush pulse → busy=1, four consecutive q_pop, no cons_valid, count reaches 0, busy=0; inject q_pop_valid=0 once → err=1 and stays set until rst.
